// File: rtl/hnf_pocq_tracker.sv
// HN-F point-of-coherence queue: allocates RN requests, dispatches them round-robin and retires
// them on CompAck. Define HNF_POCQ_ADDR_HAZARD_EN to serialise same-line requests via SLEEP.
package hnf_pocq_pkg;
    localparam int unsigned ADDR_W = 44;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [ADDR_W-1:0] addr;
        logic [6:0]        tgt_id;
        logic [6:0]        src_id;
        logic [7:0]        txn_id;
    } reqflit_t;

    typedef struct packed {
        logic [4:0] opcode;
        logic [6:0] tgt_id;
        logic [6:0] src_id;
        logic [7:0] txn_id;
    } rspflit_t;
endpackage

module hnf_pocq_tracker
    import hnf_pocq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LINE_OFF = 6,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  reqflit_t         req_flit,
    output logic             dispatch_valid,
    input  logic             dispatch_ready,
    output reqflit_t         dispatch_flit,
    output logic [IDX_W-1:0] dispatch_idx,
    input  logic             mem_issued_v,
    input  logic [IDX_W-1:0] mem_issued_idx,
    input  logic             rsp_valid,
    input  rspflit_t         rsp_flit,
    output logic             retire_valid,
    output reqflit_t         retire_flit,
    output logic             rsp_miss,
    output logic [IDX_W:0]   occupancy,
    output logic             empty,
    output logic             full
);

    typedef enum logic [2:0] {StFree, StPend, StActive, StWaitAck, StSleep} state_e;

    state_e           state_q [DEPTH];
    state_e           state_d [DEPTH];
    reqflit_t         flit_q  [DEPTH];
    reqflit_t         flit_d  [DEPTH];
    logic             hold_q, hold_d;
    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W:0]   occupancy_q, occupancy_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             retire_valid_q, retire_valid_d;
    reqflit_t         retire_flit_q, retire_flit_d;
    logic             rsp_miss_q, rsp_miss_d;

    logic             alloc;
    logic [IDX_W-1:0] alloc_idx;
    logic             ret_hit;
    logic [IDX_W-1:0] ret_idx;
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;

    logic unused_rsp;
    assign unused_rsp = ^{rsp_flit.src_id, rsp_flit.opcode};

    // Lowest-index FREE entry and lowest-index matching WAIT_ACK entry.
    always_comb begin
        alloc_idx = '0;
        ret_hit   = 1'b0;
        ret_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == StFree) begin
                alloc_idx = IDX_W'(i);
            end
            if (rsp_valid && state_q[i] == StWaitAck &&
                flit_q[i].txn_id == rsp_flit.txn_id && flit_q[i].src_id == rsp_flit.tgt_id) begin
                ret_hit = 1'b1;
                ret_idx = IDX_W'(i);
            end
        end
        alloc = req_valid && !full_q;
    end

    // Round-robin search starts just after the last granted index; k == DEPTH wraps onto it.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            cand = last_q + IDX_W'(k);
            if (!rr_found && state_q[cand] == StPend) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign sel_idx        = hold_q ? hold_idx_q : rr_idx;
    assign dispatch_valid = hold_q || rr_found;
    assign dispatch_idx   = dispatch_valid ? sel_idx : '0;
    assign dispatch_flit  = dispatch_valid ? flit_q[sel_idx] : '0;
    assign accept         = dispatch_valid && dispatch_ready;

`ifdef HNF_POCQ_ADDR_HAZARD_EN
    logic [IDX_W-1:0] blocker_q [DEPTH];
    logic [IDX_W-1:0] blocker_d [DEPTH];
    logic [DEPTH-1:0] is_blocker;
    logic             haz_hit;
    logic [IDX_W-1:0] haz_idx;

    // The youngest same-line entry is the chain tail: the one no sleeper is waiting on.
    always_comb begin
        is_blocker = '0;
        haz_hit    = 1'b0;
        haz_idx    = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (state_q[j] == StSleep) begin
                is_blocker[blocker_q[j]] = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != StFree && !(ret_hit && ret_idx == IDX_W'(i)) && !is_blocker[i] &&
                flit_q[i].addr[ADDR_W-1:LINE_OFF] == req_flit.addr[ADDR_W-1:LINE_OFF]) begin
                haz_hit = 1'b1;
                haz_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
`ifdef HNF_POCQ_ADDR_HAZARD_EN
        blocker_d = blocker_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (state_q[j] == StSleep && ret_hit && blocker_q[j] == ret_idx) begin
                state_d[j] = StPend;
            end
        end
`endif
        if (accept) begin
            state_d[sel_idx] = StActive;
        end
        if (mem_issued_v && state_q[mem_issued_idx] == StActive) begin
            state_d[mem_issued_idx] = StWaitAck;
        end
        if (ret_hit) begin
            state_d[ret_idx] = StFree;
        end
        if (alloc) begin
            flit_d[alloc_idx]  = req_flit;
            state_d[alloc_idx] = StPend;
`ifdef HNF_POCQ_ADDR_HAZARD_EN
            if (haz_hit) begin
                state_d[alloc_idx]   = StSleep;
                blocker_d[alloc_idx] = haz_idx;
            end
`endif
        end

        hold_d      = dispatch_valid && !dispatch_ready;
        hold_idx_d  = sel_idx;
        last_d      = accept ? sel_idx : last_q;
        occupancy_d = occupancy_q + {{IDX_W{1'b0}}, alloc} - {{IDX_W{1'b0}}, ret_hit};
        empty_d     = (occupancy_d == '0);
        full_d      = (occupancy_d == (IDX_W + 1)'(DEPTH));

        retire_valid_d = ret_hit;
        retire_flit_d  = ret_hit ? flit_q[ret_idx] : '0;
        rsp_miss_d     = rsp_valid && !ret_hit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= StFree;
                flit_q[i]  <= '0;
`ifdef HNF_POCQ_ADDR_HAZARD_EN
                blocker_q[i] <= '0;
`endif
            end
            hold_q         <= 1'b0;
            hold_idx_q     <= '0;
            last_q         <= '1;
            occupancy_q    <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_flit_q  <= '0;
            rsp_miss_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            flit_q         <= flit_d;
`ifdef HNF_POCQ_ADDR_HAZARD_EN
            blocker_q      <= blocker_d;
`endif
            hold_q         <= hold_d;
            hold_idx_q     <= hold_idx_d;
            last_q         <= last_d;
            occupancy_q    <= occupancy_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            retire_valid_q <= retire_valid_d;
            retire_flit_q  <= retire_flit_d;
            rsp_miss_q     <= rsp_miss_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset && mem_issued_v && state_q[mem_issued_idx] != StActive) begin
            $error("mem_issued_v for entry %0d which is not ACTIVE", mem_issued_idx);
        end
    end
`endif

    assign req_ready    = !full_q;
    assign occupancy    = occupancy_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign retire_valid = retire_valid_q;
    assign retire_flit  = retire_flit_q;
    assign rsp_miss     = rsp_miss_q;

endmodule

// File: tb/tb_hnf_pocq_tracker.sv
// Directed bench for hnf_pocq_tracker: a vector table for the basic lifecycle plus hand-written
// sequences for fill/refill, round-robin hold, simultaneous events, reset and line hazards.
module tb_hnf_pocq_tracker;
    import hnf_pocq_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    reqflit_t         req_flit;
    logic             dispatch_valid;
    logic             dispatch_ready;
    reqflit_t         dispatch_flit;
    logic [IDX_W-1:0] dispatch_idx;
    logic             mem_issued_v;
    logic [IDX_W-1:0] mem_issued_idx;
    logic             rsp_valid;
    rspflit_t         rsp_flit;
    logic             retire_valid;
    reqflit_t         retire_flit;
    logic             rsp_miss;
    logic [IDX_W:0]   occupancy;
    logic             empty;
    logic             full;

    int n_checks = 0;
    int n_errors = 0;

    hnf_pocq_tracker #(.DEPTH(DEPTH), .LINE_OFF(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_flit       (req_flit),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_flit  (dispatch_flit),
        .dispatch_idx   (dispatch_idx),
        .mem_issued_v   (mem_issued_v),
        .mem_issued_idx (mem_issued_idx),
        .rsp_valid      (rsp_valid),
        .rsp_flit       (rsp_flit),
        .retire_valid   (retire_valid),
        .retire_flit    (retire_flit),
        .rsp_miss       (rsp_miss),
        .occupancy      (occupancy),
        .empty          (empty),
        .full           (full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        req_v;
        logic [7:0]  req_txn;
        logic [6:0]  req_src;
        logic [43:0] req_addr;
        logic        disp_rdy;
        logic        mem_v;
        logic [3:0]  mem_idx;
        logic        rsp_v;
        logic [7:0]  rsp_txn;
        logic [6:0]  rsp_tgt;
        logic        exp_dv;
        logic [3:0]  exp_didx;
        logic        exp_rv;
        logic [7:0]  exp_rtxn;
        logic        exp_miss;
        logic [4:0]  exp_occ;
        logic        exp_empty;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic reqflit_t mk_req(input logic [7:0] txn, input logic [6:0] src,
                                        input logic [43:0] addr);
        reqflit_t f;
        f        = '0;
        f.txn_id = txn;
        f.src_id = src;
        f.addr   = addr;
        return f;
    endfunction

    task automatic idle_inputs;
        req_valid      = 1'b0;
        req_flit       = '0;
        dispatch_ready = 1'b0;
        mem_issued_v   = 1'b0;
        mem_issued_idx = '0;
        rsp_valid      = 1'b0;
        rsp_flit       = '0;
    endtask

    task automatic send_rsp(input logic [7:0] txn, input logic [6:0] tgt);
        rsp_valid       = 1'b1;
        rsp_flit        = '0;
        rsp_flit.txn_id = txn;
        rsp_flit.tgt_id = tgt;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        // req_v txn src addr | rdy | mem_v idx | rsp_v txn tgt | dv didx rv rtxn miss occ empty
        vecs[0] = '{0, 8'd0, 7'd0, 44'h0,   0, 0, 4'd0, 0, 8'd0, 7'd0, 0, 4'd0, 0, 8'd0, 0, 5'd0, 1};
        vecs[1] = '{1, 8'd5, 7'd2, 44'h100, 0, 0, 4'd0, 0, 8'd0, 7'd0, 1, 4'd0, 0, 8'd0, 0, 5'd1, 0};
        vecs[2] = '{0, 8'd0, 7'd0, 44'h0,   1, 0, 4'd0, 0, 8'd0, 7'd0, 0, 4'd0, 0, 8'd0, 0, 5'd1, 0};
        vecs[3] = '{0, 8'd0, 7'd0, 44'h0,   0, 1, 4'd0, 0, 8'd0, 7'd0, 0, 4'd0, 0, 8'd0, 0, 5'd1, 0};
        vecs[4] = '{0, 8'd0, 7'd0, 44'h0,   0, 0, 4'd0, 1, 8'd5, 7'd2, 0, 4'd0, 1, 8'd5, 0, 5'd0, 1};
        vecs[5] = '{0, 8'd0, 7'd0, 44'h0,   0, 0, 4'd0, 0, 8'd0, 7'd0, 0, 4'd0, 0, 8'd0, 0, 5'd0, 1};
        vecs[6] = '{1, 8'd7, 7'd1, 44'h200, 0, 0, 4'd0, 0, 8'd0, 7'd0, 1, 4'd0, 0, 8'd0, 0, 5'd1, 0};
        vecs[7] = '{0, 8'd0, 7'd0, 44'h0,   0, 0, 4'd0, 1, 8'd9, 7'd2, 1, 4'd0, 0, 8'd0, 1, 5'd1, 0};
        vecs[8] = '{0, 8'd0, 7'd0, 44'h0,   0, 0, 4'd0, 0, 8'd0, 7'd0, 1, 4'd0, 0, 8'd0, 0, 5'd1, 0};
        // Matching IDs but the entry is still PEND, not WAIT_ACK.
        vecs[9] = '{0, 8'd0, 7'd0, 44'h0,   0, 0, 4'd0, 1, 8'd7, 7'd1, 1, 4'd0, 0, 8'd0, 1, 5'd1, 0};

        do_reset();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_full", full, 0);
        chk("reset_dispatch_flit", dispatch_flit, 0);
        chk("reset_retire_flit", retire_flit, 0);

        for (int v = 0; v < 10; v++) begin
            req_valid      = vecs[v].req_v;
            req_flit       = mk_req(vecs[v].req_txn, vecs[v].req_src, vecs[v].req_addr);
            dispatch_ready = vecs[v].disp_rdy;
            mem_issued_v   = vecs[v].mem_v;
            mem_issued_idx = vecs[v].mem_idx;
            rsp_valid      = 1'b0;
            rsp_flit       = '0;
            if (vecs[v].rsp_v) send_rsp(vecs[v].rsp_txn, vecs[v].rsp_tgt);
            tick();
            chk($sformatf("v%0d_dispatch_valid", v), dispatch_valid, vecs[v].exp_dv);
            chk($sformatf("v%0d_dispatch_idx", v), dispatch_idx, vecs[v].exp_didx);
            chk($sformatf("v%0d_retire_valid", v), retire_valid, vecs[v].exp_rv);
            chk($sformatf("v%0d_retire_txn", v), retire_flit.txn_id, vecs[v].exp_rtxn);
            chk($sformatf("v%0d_rsp_miss", v), rsp_miss, vecs[v].exp_miss);
            chk($sformatf("v%0d_occupancy", v), occupancy, vecs[v].exp_occ);
            chk($sformatf("v%0d_empty", v), empty, vecs[v].exp_empty);
        end
        idle_inputs();

        // Fill all 16 entries, free entry 7, refill it.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_flit  = mk_req(8'(i), 7'd1, 44'(i * 64));
            tick();
            chk($sformatf("fill_occ_%0d", i), occupancy, i + 1);
            chk($sformatf("fill_hold_idx_%0d", i), dispatch_idx, 0);
        end
        req_flit = mk_req(8'h55, 7'd1, 44'h5500);
        chk("full_flag", full, 1);
        chk("full_req_ready", req_ready, 0);
        tick();
        chk("full_ignores_req", occupancy, 16);
        req_valid      = 1'b0;
        dispatch_ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            chk($sformatf("rr_grant_%0d", g), dispatch_idx, g);
            tick();
        end
        dispatch_ready = 1'b0;
        mem_issued_v   = 1'b1;
        mem_issued_idx = 4'd7;
        tick();
        mem_issued_v = 1'b0;
        send_rsp(8'd7, 7'd1);
        req_valid = 1'b1;
        req_flit  = mk_req(8'h77, 7'd1, 44'h7700);
        chk("retire_cycle_req_ready", req_ready, 0);
        tick();
        rsp_valid = 1'b0;
        chk("e7_retire_valid", retire_valid, 1);
        chk("e7_retire_txn", retire_flit.txn_id, 8'd7);
        chk("e7_occ_after_retire", occupancy, 15);
        chk("e7_full_after_retire", full, 0);
        chk("e7_req_ready_after", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("refill_occ", occupancy, 16);
        chk("refill_full", full, 1);
        chk("refill_retire_pulse_gone", retire_valid, 0);
        dispatch_ready = 1'b1;
        for (int g = 8; g < 16; g++) begin
            chk($sformatf("rr_grant_%0d", g), dispatch_idx, g);
            tick();
        end
        chk("refill_slot_idx", dispatch_idx, 7);
        chk("refill_slot_txn", dispatch_flit.txn_id, 8'h77);
        dispatch_ready = 1'b0;

        // Hold dispatch with three PEND entries, then grant in round-robin order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_flit  = mk_req(8'(10 + i), 7'd2, 44'h3000 + 44'(i * 64));
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold_idx_%0d", i), dispatch_idx, 0);
            chk($sformatf("hold_txn_%0d", i), dispatch_flit.txn_id, 8'd10);
            tick();
        end
        dispatch_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rr3_idx_%0d", g), dispatch_idx, g);
            chk($sformatf("rr3_txn_%0d", g), dispatch_flit.txn_id, 10 + g);
            tick();
        end
        dispatch_ready = 1'b0;
        chk("rr3_drained", dispatch_valid, 0);

        // Alloc to entry 3, retire entry 1, accept entry 2 and mem issue entry 0 together.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_flit  = mk_req(8'(20 + i), 7'd3, 44'h2000 + 44'(i * 64));
            tick();
        end
        req_valid      = 1'b0;
        dispatch_ready = 1'b1;
        chk("sim_grant0", dispatch_idx, 0);
        tick();
        chk("sim_grant1", dispatch_idx, 1);
        tick();
        dispatch_ready = 1'b0;
        mem_issued_v   = 1'b1;
        mem_issued_idx = 4'd1;
        tick();
        chk("sim_pre_idx", dispatch_idx, 2);
        req_valid      = 1'b1;
        req_flit       = mk_req(8'd23, 7'd3, 44'h20C0);
        send_rsp(8'd21, 7'd3);
        dispatch_ready = 1'b1;
        mem_issued_idx = 4'd0;
        tick();
        idle_inputs();
        chk("sim_retire_valid", retire_valid, 1);
        chk("sim_retire_txn", retire_flit.txn_id, 8'd21);
        chk("sim_occ", occupancy, 3);
        chk("sim_new_idx", dispatch_idx, 3);
        chk("sim_new_txn", dispatch_flit.txn_id, 8'd23);
        send_rsp(8'd20, 7'd5);
        tick();
        rsp_valid = 1'b0;
        chk("wrong_tgt_miss", rsp_miss, 1);
        chk("wrong_tgt_no_retire", retire_valid, 0);
        chk("wrong_tgt_occ", occupancy, 3);
        // Entry 0 is in WAIT_ACK; reset now must drop it silently.
        reset = 1'b1;
        tick();
        chk("midreset_occ", occupancy, 0);
        chk("midreset_empty", empty, 1);
        chk("midreset_dv", dispatch_valid, 0);
        reset = 1'b0;
        tick();
        chk("midreset_no_retire", retire_valid, 0);
        chk("midreset_no_miss", rsp_miss, 0);

        // Two requests to the same 64-byte line.
        do_reset();
        req_valid = 1'b1;
        req_flit  = mk_req(8'd30, 7'd4, 44'h1040);
        tick();
        req_flit       = mk_req(8'd31, 7'd4, 44'h1078);
        dispatch_ready = 1'b1;
        chk("haz_first_idx", dispatch_idx, 0);
        tick();
        req_valid      = 1'b0;
        dispatch_ready = 1'b0;
        chk("haz_occ", occupancy, 2);
`ifdef HNF_POCQ_ADDR_HAZARD_EN
        chk("haz_second_blocked", dispatch_valid, 0);
`else
        chk("haz_second_b2b", dispatch_valid, 1);
        chk("haz_second_b2b_idx", dispatch_idx, 1);
`endif
        mem_issued_v   = 1'b1;
        mem_issued_idx = 4'd0;
        tick();
        mem_issued_v = 1'b0;
`ifdef HNF_POCQ_ADDR_HAZARD_EN
        chk("haz_still_blocked", dispatch_valid, 0);
`else
        chk("haz_still_pending", dispatch_valid, 1);
`endif
        send_rsp(8'd30, 7'd4);
        tick();
        rsp_valid = 1'b0;
        chk("haz_retire", retire_valid, 1);
        chk("haz_retire_txn", retire_flit.txn_id, 8'd30);
        chk("haz_after_dv", dispatch_valid, 1);
        chk("haz_after_idx", dispatch_idx, 1);
        chk("haz_after_txn", dispatch_flit.txn_id, 8'd31);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
